// File: rtl/cache_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the 2-way write-through read cache.
package cache_ctrl_pkg;
  localparam int ADDR_W    = 16;
  localparam int SETS_LG2  = 6;
  localparam int SETS      = 1 << SETS_LG2;
  localparam int LINE_W    = 64;
  localparam int WORD_W    = 32;
  localparam int WORD_SEL  = 2;
  localparam int INDEX_LSB = 3;
  localparam int TAG_LSB   = SETS_LG2 + 3;
  localparam int TAG_W     = ADDR_W - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// MEM_Stage request bus plus SRAM controller bus seen by the cache.
// Handshake: a request (MEM_R_EN/MEM_W_EN) completes in the cycle ready=1; while ready=0 the
// requester holds address/data stable. SRAM requests (sram_r_en/sram_w_en) stay high until the
// one-cycle sram_ready pulse that completes them.
interface cache_ctrl_if;
  import cache_ctrl_pkg::*;

  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] writeData;
  logic [WORD_W-1:0] readData;
  logic              ready;
  logic              sram_r_en;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_address;
  logic [WORD_W-1:0] sram_wdata;
  logic [LINE_W-1:0] sram_rdata;
  logic              sram_ready;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, writeData, sram_rdata, sram_ready,
    output readData, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, writeData, sram_rdata, sram_ready,
    input  readData, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );
endinterface

// File: rtl/cache_ctrl_way_array.sv
// One cache way: valid/tag/line storage with combinational lookup and synchronous fill/word write.
module cache_way_array
  import cache_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SETS_LG2-1:0] index,
  input  logic [TAG_W-1:0]    tag,
  output logic                hit,
  output logic [LINE_W-1:0]   line,
  input  logic                fill_en,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic                word_wr_en,
  input  logic                word_sel,
  input  logic [WORD_W-1:0]   word_data
);
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  assign hit  = valid[index] && (tags[index] == tag);
  assign line = lines[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag/data need no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index]  <= tag;
      lines[index] <= fill_line;
    end else if (word_wr_en) begin
      if (word_sel) lines[index][LINE_W-1:WORD_W] <= word_data;
      else          lines[index][WORD_W-1:0]      <= word_data;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate read cache between MEM_Stage and SRAM.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.slave bus,
  output state_t      state_dbg
);
  state_t              state, state_n;
  logic [SETS-1:0]     lru;
  logic [SETS_LG2-1:0] index;
  logic [TAG_W-1:0]    tag;
  logic                word_sel;
  logic [1:0]          hit_w;
  logic [LINE_W-1:0]   line_w [2];
  logic                hit, hit_way, victim;
  logic                fill_en, word_wr_en, lru_upd, lru_way, writing;

  assign index     = bus.address[INDEX_LSB +: SETS_LG2];
  assign tag       = bus.address[TAG_LSB +: TAG_W];
  assign word_sel  = bus.address[WORD_SEL];
  assign hit       = |hit_w;
  assign hit_way   = ~hit_w[0];
  assign victim    = lru[index];
  assign state_dbg = state;

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_array u_way (
      .clk        (clk),
      .rst        (rst),
      .index      (index),
      .tag        (tag),
      .hit        (hit_w[w]),
      .line       (line_w[w]),
      .fill_en    (fill_en && (victim == 1'(w))),
      .fill_line  (bus.sram_rdata),
      .word_wr_en (word_wr_en && hit_w[w]),
      .word_sel   (word_sel),
      .word_data  (bus.writeData)
    );
  end

  // Reads fetch the whole line, so the word-select bit is cleared; writes go out per word.
  assign writing          = (state == WR_THRU) || ((state == IDLE) && bus.MEM_W_EN);
  assign bus.sram_address = writing ? bus.address
                                    : {bus.address[ADDR_W-1:WORD_SEL+1], 1'b0, bus.address[WORD_SEL-1:0]};
  assign bus.sram_wdata   = bus.writeData;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lru   <= '0;
    end else begin
      state <= state_n;
      if (lru_upd) lru[index] <= ~lru_way;
    end
  end

  always_comb begin
    state_n       = state;
    bus.ready     = 1'b1;
    bus.readData  = '0;
    bus.sram_r_en = 1'b0;
    bus.sram_w_en = 1'b0;
    fill_en       = 1'b0;
    word_wr_en    = 1'b0;
    lru_upd       = 1'b0;
    lru_way       = 1'b0;
    unique case (state)
      IDLE: begin
        // A simultaneous read+write is treated as a write so the arrays see one consistent op.
        if (bus.MEM_W_EN) begin
          bus.ready     = 1'b0;
          bus.sram_w_en = 1'b1;
          state_n       = WR_THRU;
        end else if (bus.MEM_R_EN) begin
          if (hit) begin
            bus.readData = pick_word(line_w[hit_way], word_sel);
            lru_upd      = 1'b1;
            lru_way      = hit_way;
          end else begin
            bus.ready     = 1'b0;
            bus.sram_r_en = 1'b1;
            state_n       = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        bus.sram_r_en = 1'b1;
        bus.ready     = 1'b0;
        if (bus.sram_ready) begin
          fill_en      = 1'b1;
          lru_upd      = 1'b1;
          lru_way      = victim;
          bus.readData = pick_word(bus.sram_rdata, word_sel);
          bus.ready    = 1'b1;
          state_n      = IDLE;
        end
      end
      WR_THRU: begin
        bus.sram_w_en = 1'b1;
        bus.ready     = 1'b0;
        if (bus.sram_ready) begin
          word_wr_en = hit;
          lru_upd    = hit;
          lru_way    = hit_way;
          bus.ready  = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
